// File: rtl/upc_pkg.sv
// Shared types for the UPC checkout monitor.
// Holds the FSM state encoding and the key synchroniser depth.
package upc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    EVAL,
    ALARM
  } chk_state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/key_sync_edge.sv
// Double-flop synchroniser for an active-low key.
// Emits a one-cycle pulse on each press (falling edge).
module key_sync_edge
  import upc_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], key_n};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign pulse = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/upc_checkout_monitor.sv
// Checkout monitor: samples a scanned UPC, classifies it,
// keeps saturating counts and latches a stolen-item alarm.
module upc_checkout_monitor
  import upc_pkg::*;
#(
  parameter int                     UPC_W      = 3,
  parameter logic [(1<<UPC_W)-1:0] VALID_MASK = '1,
  parameter logic [(1<<UPC_W)-1:0] DISC_MASK  = 'b0000_0110,
  parameter logic [(1<<UPC_W)-1:0] EXP_MASK   = 'b0000_1001,
  parameter int                     CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [UPC_W-1:0] upc,
  input  logic             marked,
  input  logic             scan_key_n,
  input  logic             ack_key_n,
  output logic [UPC_W-1:0] last_upc,
  output logic             discounted,
  output logic             invalid,
  output logic             alarm,
  output logic             busy,
  output logic [CNT_W-1:0] item_count,
  output logic [CNT_W-1:0] disc_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic scan_p, ack_p;

  key_sync_edge u_scan_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .key_n   (scan_key_n),
    .pulse   (scan_p)
  );

  key_sync_edge u_ack_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .key_n   (ack_key_n),
    .pulse   (ack_p)
  );

  chk_state_t       state_q, state_d;
  logic [UPC_W-1:0] upc_s1_q, upc_s1_d;
  logic [UPC_W-1:0] upc_s2_q, upc_s2_d;
  logic             mark_s1_q, mark_s1_d;
  logic             mark_s2_q, mark_s2_d;
  logic [UPC_W-1:0] cap_upc_q, cap_upc_d;
  logic             cap_mark_q, cap_mark_d;
  logic [UPC_W-1:0] last_upc_q, last_upc_d;
  logic             disc_q, disc_d;
  logic             inv_q, inv_d;
  logic             alarm_q, alarm_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] item_q, item_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;

  always_comb begin
    state_d    = state_q;
    upc_s1_d   = upc;
    upc_s2_d   = upc_s1_q;
    mark_s1_d  = marked;
    mark_s2_d  = mark_s1_q;
    cap_upc_d  = cap_upc_q;
    cap_mark_d = cap_mark_q;
    last_upc_d = last_upc_q;
    disc_d     = disc_q;
    inv_d      = inv_q;
    alarm_d    = alarm_q;
    item_d     = item_q;
    dcnt_d     = dcnt_q;

    unique case (state_q)
      IDLE: begin
        if (scan_p) state_d = CAPTURE;
      end
      CAPTURE: begin
        cap_upc_d  = upc_s2_q;
        cap_mark_d = mark_s2_q;
        state_d    = EVAL;
      end
      EVAL: begin
        state_d = IDLE;
        if (!VALID_MASK[cap_upc_q]) begin
          inv_d = 1'b1;
        end else begin
          inv_d      = 1'b0;
          last_upc_d = cap_upc_q;
          disc_d     = DISC_MASK[cap_upc_q];
          if (item_q != CNT_MAX) item_d = item_q + 1'b1;
          if (DISC_MASK[cap_upc_q] && dcnt_q != CNT_MAX)
            dcnt_d = dcnt_q + 1'b1;
          // expensive and unmarked: hold until acknowledged
          if (EXP_MASK[cap_upc_q] && !cap_mark_q) begin
            alarm_d = 1'b1;
            state_d = ALARM;
          end
        end
      end
      ALARM: begin
        if (ack_p) begin
          alarm_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      upc_s1_q   <= '0;
      upc_s2_q   <= '0;
      mark_s1_q  <= 1'b0;
      mark_s2_q  <= 1'b0;
      cap_upc_q  <= '0;
      cap_mark_q <= 1'b0;
      last_upc_q <= '0;
      disc_q     <= 1'b0;
      inv_q      <= 1'b0;
      alarm_q    <= 1'b0;
      busy_q     <= 1'b0;
      item_q     <= '0;
      dcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      upc_s1_q   <= upc_s1_d;
      upc_s2_q   <= upc_s2_d;
      mark_s1_q  <= mark_s1_d;
      mark_s2_q  <= mark_s2_d;
      cap_upc_q  <= cap_upc_d;
      cap_mark_q <= cap_mark_d;
      last_upc_q <= last_upc_d;
      disc_q     <= disc_d;
      inv_q      <= inv_d;
      alarm_q    <= alarm_d;
      busy_q     <= busy_d;
      item_q     <= item_d;
      dcnt_q     <= dcnt_d;
    end
  end

  assign last_upc   = last_upc_q;
  assign discounted = disc_q;
  assign invalid    = inv_q;
  assign alarm      = alarm_q;
  assign busy       = busy_q;
  assign item_count = item_q;
  assign disc_count = dcnt_q;

endmodule

// File: tb/tb_upc_checkout_monitor.sv
// Scoreboard bench for upc_checkout_monitor (VALID_MASK='h7F, CNT_W=2).
// Stimulus pushes expected results; a monitor pops them on completion.
module tb_upc_checkout_monitor;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] upc;
  logic       marked;
  logic       scan_key_n;
  logic       ack_key_n;
  logic [2:0] last_upc;
  logic       discounted;
  logic       invalid;
  logic       alarm;
  logic       busy;
  logic [1:0] item_count;
  logic [1:0] disc_count;

  typedef struct packed {
    logic [2:0] lu;
    logic       d;
    logic       i;
    logic       a;
    logic       b;
    logic [1:0] ic;
    logic [1:0] dc;
  } exp_t;

  exp_t  q[$];
  string tq[$];
  int    checks = 0;
  int    failures = 0;
  logic  pb = 1'b0;
  logic  pa = 1'b0;

  upc_checkout_monitor #(
    .UPC_W      (3),
    .VALID_MASK (8'h7F),
    .CNT_W      (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .upc        (upc),
    .marked     (marked),
    .scan_key_n (scan_key_n),
    .ack_key_n  (ack_key_n),
    .last_upc   (last_upc),
    .discounted (discounted),
    .invalid    (invalid),
    .alarm      (alarm),
    .busy       (busy),
    .item_count (item_count),
    .disc_count (disc_count)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(int lu, bit d, bit i, bit a,
                              bit b, int ic, int dc);
    exp_t e;
    e.lu = 3'(lu);
    e.d  = d;
    e.i  = i;
    e.a  = a;
    e.b  = b;
    e.ic = 2'(ic);
    e.dc = 2'(dc);
    return e;
  endfunction

  function automatic exp_t cur();
    return {last_upc, discounted, invalid, alarm, busy,
            item_count, disc_count};
  endfunction

  task automatic check(string name, exp_t act, exp_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act: upc=%0d d=%b i=%b a=%b b=%b n=%0d dn=%0d req: upc=%0d d=%b i=%b a=%b b=%b n=%0d dn=%0d",
               name, act.lu, act.d, act.i, act.a, act.b, act.ic, act.dc,
               exp.lu, exp.d, exp.i, exp.a, exp.b, exp.ic, exp.dc);
    end
  endtask

  // a result is presented when busy drops or the alarm rises
  always @(negedge clk) begin
    if (!reset_n) begin
      pb = 1'b0;
      pa = 1'b0;
    end else begin
      if ((pb && !busy) || (!pa && alarm)) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result upc=%0d a=%b b=%b n=%0d",
                   last_upc, alarm, busy, item_count);
        end else begin
          check(tq.pop_front(), cur(), q.pop_front());
        end
      end
      pb = busy;
      pa = alarm;
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(bit s, bit a, int hold);
    scan_key_n = !s;
    ack_key_n  = !a;
    tick(hold);
    scan_key_n = 1'b1;
    ack_key_n  = 1'b1;
    tick(6);
  endtask

  task automatic drain(string name);
    for (int i = 0; i < 60 && q.size() != 0; i++) tick(1);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout pending=%0d req=0", name, q.size());
      q.delete();
      tq.delete();
    end
  endtask

  task automatic expect_push(string name, exp_t e);
    q.push_back(e);
    tq.push_back(name);
  endtask

  task automatic scan(string name, int code, bit mk_bit,
                      bit with_ack, exp_t e);
    upc    = 3'(code);
    marked = mk_bit;
    tick(2);
    expect_push(name, e);
    press(1'b1, with_ack, 4);
    drain(name);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(2);
  endtask

  initial begin
    reset_n    = 1'b0;
    upc        = '0;
    marked     = 1'b0;
    scan_key_n = 1'b1;
    ack_key_n  = 1'b1;
    tick(3);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check($sformatf("reset_idle_%0d", i), cur(), '0);
    end

    upc    = 3'd1;
    marked = 1'b0;
    tick(2);
    expect_push("held_scan_one_item", mk(1, 1, 0, 0, 0, 1, 1));
    press(1'b1, 1'b0, 20);
    drain("held_scan");

    scan("stolen_alarm", 0, 1'b0, 1'b0, mk(0, 0, 0, 1, 1, 2, 1));
    upc = 3'd1;
    tick(2);
    press(1'b1, 1'b0, 4);
    tick(4);
    check("scan_dropped_in_alarm", cur(), mk(0, 0, 0, 1, 1, 2, 1));
    expect_push("ack_clears", mk(0, 0, 0, 0, 0, 2, 1));
    press(1'b0, 1'b1, 4);
    drain("ack");

    scan("marked_expensive", 0, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 3, 1));
    scan("invalid_code7", 7, 1'b0, 1'b0, mk(0, 0, 1, 0, 0, 3, 1));
    scan("valid_after_inv", 2, 1'b0, 1'b0, mk(2, 1, 0, 0, 0, 3, 2));

    do_reset();
    check("reset_clears", cur(), '0);
    for (int k = 1; k <= 5; k++) begin
      int c;
      c = (k > 3) ? 3 : k;
      scan($sformatf("sat_scan_%0d", k), 2, 1'b0, 1'b0,
           mk(2, 1, 0, 0, 0, c, c));
    end

    upc = 3'd2;
    tick(2);
    scan_key_n = 1'b0;
    begin
      int n;
      n = 0;
      while (!busy && n < 20) begin
        tick(1);
        n++;
      end
      checks++;
      if (!busy) begin
        failures++;
        $display("FAIL busy_rise_timeout busy=%b req=1", busy);
      end
    end
    tick(1);
    reset_n = 1'b0;
    #1;
    check("async_reset_in_eval", cur(), '0);
    scan_key_n = 1'b1;
    tick(3);
    reset_n = 1'b1;
    tick(5);
    check("idle_after_reset", cur(), '0);

    scan("scan_ack_idle", 1, 1'b0, 1'b1, mk(1, 1, 0, 0, 0, 1, 1));
    scan("alarm_code3", 3, 1'b0, 1'b0, mk(3, 0, 0, 1, 1, 2, 1));
    upc = 3'd1;
    tick(2);
    expect_push("scan_ack_alarm", mk(3, 0, 0, 0, 0, 2, 1));
    press(1'b1, 1'b1, 4);
    drain("scan_ack_alarm");
    tick(8);
    check("final_idle", cur(), mk(3, 0, 0, 0, 0, 2, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
